// File: rtl/cpu_mem_pkg.sv
// Shared memory-interface defaults and the read-response owner encoding.
package cpu_mem_pkg;

    localparam int unsigned AddrWDefault = 32;
    localparam int unsigned DataWDefault = 32;

    typedef enum logic [1:0] {
        OwnerNone = 2'd0,
        OwnerInst = 2'd1,
        OwnerData = 2'd2
    } owner_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of consecutive cycles a fetch request has been denied.
module arb_starve_cnt #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic inst_req_i,
    input  logic inst_gnt_i,
    output logic at_max_o
);

    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

    logic [CntW-1:0] cnt_d, cnt_q;

    assign at_max_o = (cnt_q == CntW'(STARVE_MAX));

    always_comb begin
        cnt_d = '0;
        if (inst_req_i && !inst_gnt_i) begin
            cnt_d = at_max_o ? cnt_q : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sram_port_arb.sv
// Arbitrates one single-port synchronous SRAM between instruction fetch and EX load/store,
// favouring load/store but forcing a fetch grant once fetch has starved STARVE_MAX cycles.
module sram_port_arb
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = AddrWDefault,
    parameter int unsigned DATA_W     = DataWDefault,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_gnt,
    output logic              inst_rvalid,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic [3:0]        data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [DATA_W-1:0] data_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    owner_e pending_d, pending_q;
    logic   rst_done_q;
    logic   starve_max;

    arb_starve_cnt #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve_cnt (
        .clk_i     (clk),
        .rst_ni    (resetn),
        .inst_req_i(inst_req),
        .inst_gnt_i(inst_gnt),
        .at_max_o  (starve_max)
    );

    // rst_done_q holds off grants until the first edge after reset release has passed.
    always_comb begin
        data_gnt = 1'b0;
        inst_gnt = 1'b0;
        if (rst_done_q) begin
            if (data_req && !(inst_req && starve_max)) begin
                data_gnt = 1'b1;
            end else if (inst_req) begin
                inst_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        sram_en    = data_gnt | inst_gnt;
        sram_we    = data_gnt ? data_we : 4'b0000;
        sram_addr  = data_gnt ? data_addr : (inst_gnt ? inst_addr : '0);
        sram_wdata = data_gnt ? data_wdata : '0;
    end

    always_comb begin
        pending_d = OwnerNone;
        if (inst_gnt) begin
            pending_d = OwnerInst;
        end else if (data_gnt && (data_we == 4'b0000)) begin
            pending_d = OwnerData;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pending_q  <= OwnerNone;
            rst_done_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            rst_done_q <= 1'b1;
        end
    end

    assign inst_rvalid = (pending_q == OwnerInst);
    assign data_rvalid = (pending_q == OwnerData);
    assign inst_rdata  = resetn ? sram_rdata : '0;
    assign data_rdata  = resetn ? sram_rdata : '0;

endmodule

// File: tb/tb_sram_port_arb.sv
// Directed bench for sram_port_arb with a behavioural single-port SRAM model.
module tb_sram_port_arb;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_gnt, inst_rvalid;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [3:0]  data_we;
    logic [31:0] data_addr, data_wdata;
    logic        data_gnt, data_rvalid;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    sram_port_arb #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .STARVE_MAX(4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .inst_req   (inst_req),
        .inst_addr  (inst_addr),
        .inst_gnt   (inst_gnt),
        .inst_rvalid(inst_rvalid),
        .inst_rdata (inst_rdata),
        .data_req   (data_req),
        .data_we    (data_we),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .data_gnt   (data_gnt),
        .data_rvalid(data_rvalid),
        .data_rdata (data_rdata),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    // SRAM model: unwritten words read as 0xC0DE0000 | word index.
    logic [31:0] mem [256];
    logic        written [256];

    always @(posedge clk) begin
        if (sram_en) begin
            automatic logic [7:0]  idx = sram_addr[9:2];
            automatic logic [31:0] w   = written[idx] ? mem[idx] : (32'hC0DE_0000 | 32'(idx));
            if (sram_we == 4'b0000) begin
                sram_rdata <= w;
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_we[b]) w[8*b +: 8] = sram_wdata[8*b +: 8];
                end
                mem[idx]     <= w;
                written[idx] <= 1'b1;
            end
        end
    end

    // A held, ungranted request must keep its payload stable.
    logic        hold_i, hold_d;
    logic [31:0] hold_iaddr, hold_daddr, hold_dwdata;
    logic [3:0]  hold_dwe;

    always @(posedge clk) begin
        if (resetn && hold_i && inst_req)
            assert (inst_addr == hold_iaddr) else $error("unstable held fetch request");
        if (resetn && hold_d && data_req)
            assert ({data_addr, data_we, data_wdata} == {hold_daddr, hold_dwe, hold_dwdata})
                else $error("unstable held load/store request");
        hold_i      <= resetn && inst_req && !inst_gnt;
        hold_d      <= resetn && data_req && !data_gnt;
        hold_iaddr  <= inst_addr;
        hold_daddr  <= data_addr;
        hold_dwe    <= data_we;
        hold_dwdata <= data_wdata;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inst(input logic req, input logic [31:0] addr);
        inst_req  = req;
        inst_addr = addr;
    endtask

    task automatic set_data(input logic req, input logic [3:0] we, input logic [31:0] addr,
                            input logic [31:0] wdata);
        data_req   = req;
        data_we    = we;
        data_addr  = addr;
        data_wdata = wdata;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        set_inst(1'b1, 32'h1C00_0000);
        set_data(1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF);
        step();
        step();
        @(negedge clk);
        n_cmp++;
        if ({inst_gnt, data_gnt, inst_rvalid, data_rvalid, sram_en, sram_we} !== 9'd0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 0",
                     {inst_gnt, data_gnt, inst_rvalid, data_rvalid, sram_en, sram_we});
        end
        n_cmp++;
        if ({inst_rdata, data_rdata, sram_addr, sram_wdata} !== 128'd0) begin
            n_bad++;
            $display("FAIL reset_bus: got %h want 0",
                     {inst_rdata, data_rdata, sram_addr, sram_wdata});
        end
        n_cmp++;
        if (dut.u_starve_cnt.cnt_q !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_starve: got %0d want 0", dut.u_starve_cnt.cnt_q);
        end
        step();
        resetn = 1'b1;
        set_inst(1'b0, 32'h0);
        set_data(1'b1, 4'h0, 32'h8, 32'h0);
        @(negedge clk);
        n_cmp++;
        if ({inst_gnt, data_gnt, sram_en} !== 3'b000) begin
            n_bad++;
            $display("FAIL first_edge_no_gnt: got %b want 000", {inst_gnt, data_gnt, sram_en});
        end
        step();
        @(negedge clk);
        n_cmp++;
        if ({data_gnt, sram_en, sram_we, sram_addr} !== {1'b1, 1'b1, 4'h0, 32'h8}) begin
            n_bad++;
            $display("FAIL post_reset_gnt: got %b/%b/%h/%h want 1/1/0/00000008",
                     data_gnt, sram_en, sram_we, sram_addr);
        end
        step();
        set_data(1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        n_cmp++;
        if ({inst_rvalid, data_rvalid, data_rdata} !== {2'b01, 32'hC0DE_0002}) begin
            n_bad++;
            $display("FAIL post_reset_read: got %b%b/%h want 01/c0de0002",
                     inst_rvalid, data_rvalid, data_rdata);
        end
        step();
    endtask

    task automatic test_fetch();
        set_inst(1'b1, 32'h1C00_0000);
        @(negedge clk);
        n_cmp++;
        if ({inst_gnt, data_gnt, sram_en, sram_we, sram_addr} !==
            {3'b101, 4'h0, 32'h1C00_0000}) begin
            n_bad++;
            $display("FAIL fetch_gnt: got %b%b%b/%h/%h want 101/0/1c000000",
                     inst_gnt, data_gnt, sram_en, sram_we, sram_addr);
        end
        step();
        set_inst(1'b0, 32'h0);
        @(negedge clk);
        n_cmp++;
        if ({inst_rvalid, data_rvalid, inst_rdata, sram_en} !== {2'b10, 32'hC0DE_0000, 1'b0}) begin
            n_bad++;
            $display("FAIL fetch_resp: got %b%b/%h/%b want 10/c0de0000/0",
                     inst_rvalid, data_rvalid, inst_rdata, sram_en);
        end
        step();
    endtask

    task automatic test_write_priority();
        set_inst(1'b1, 32'h40);
        set_data(1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF);
        @(negedge clk);
        n_cmp++;
        if ({data_gnt, inst_gnt, sram_en, sram_we, sram_addr, sram_wdata} !==
            {3'b101, 4'hF, 32'h100, 32'hDEAD_BEEF}) begin
            n_bad++;
            $display("FAIL write_gnt: got %b%b%b/%h/%h/%h want 101/f/00000100/deadbeef",
                     data_gnt, inst_gnt, sram_en, sram_we, sram_addr, sram_wdata);
        end
        step();
        set_inst(1'b0, 32'h0);
        set_data(1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        n_cmp++;
        if ({inst_rvalid, data_rvalid} !== 2'b00) begin
            n_bad++;
            $display("FAIL write_no_rvalid: got %b%b want 00", inst_rvalid, data_rvalid);
        end
        step();
        set_data(1'b1, 4'h0, 32'h100, 32'h0);
        @(negedge clk);
        step();
        set_data(1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        n_cmp++;
        if ({data_rvalid, data_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
            n_bad++;
            $display("FAIL write_readback: got %b/%h want 1/deadbeef", data_rvalid, data_rdata);
        end
        step();
    endtask

    task automatic test_starvation();
        automatic logic       exp_i [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        automatic logic [2:0] exp_c [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        set_inst(1'b1, 32'h20);
        set_data(1'b1, 4'h0, 32'h10, 32'h0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({inst_gnt, data_gnt} !== {exp_i[k], ~exp_i[k]}) begin
                n_bad++;
                $display("FAIL starve_gnt[%0d]: got %b%b want %b%b",
                         k, inst_gnt, data_gnt, exp_i[k], ~exp_i[k]);
            end
            n_cmp++;
            if (dut.u_starve_cnt.cnt_q !== exp_c[k]) begin
                n_bad++;
                $display("FAIL starve_cnt[%0d]: got %0d want %0d",
                         k, dut.u_starve_cnt.cnt_q, exp_c[k]);
            end
            if (k > 0) begin
                n_cmp++;
                if ({inst_rvalid, data_rvalid, inst_rdata} !== {exp_i[k-1], ~exp_i[k-1],
                    (exp_i[k-1] ? 32'hC0DE_0008 : 32'hC0DE_0004)}) begin
                    n_bad++;
                    $display("FAIL starve_resp[%0d]: got %b%b/%h", k, inst_rvalid, data_rvalid,
                             inst_rdata);
                end
            end
            step();
        end
        set_inst(1'b0, 32'h0);
        set_data(1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        n_cmp++;
        if ({data_rvalid, inst_rvalid, dut.u_starve_cnt.cnt_q} !== {2'b10, 3'd1}) begin
            n_bad++;
            $display("FAIL starve_tail: got %b%b/%0d want 10/1",
                     data_rvalid, inst_rvalid, dut.u_starve_cnt.cnt_q);
        end
        step();
    endtask

    task automatic test_drop();
        set_inst(1'b1, 32'h30);
        set_data(1'b1, 4'h0, 32'h14, 32'h0);
        @(negedge clk);
        step();
        set_inst(1'b0, 32'h0);
        set_data(1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        n_cmp++;
        if ({inst_rvalid, data_rvalid, data_rdata} !== {2'b01, 32'hC0DE_0005}) begin
            n_bad++;
            $display("FAIL drop_resp: got %b%b/%h want 01/c0de0005",
                     inst_rvalid, data_rvalid, data_rdata);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if ({inst_rvalid, data_rvalid, sram_en, dut.u_starve_cnt.cnt_q} !== {3'b000, 3'd0}) begin
            n_bad++;
            $display("FAIL drop_forgotten: got %b%b%b/%0d want 000/0",
                     inst_rvalid, data_rvalid, sram_en, dut.u_starve_cnt.cnt_q);
        end
        step();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            set_inst(k % 2 == 0, 32'h0);
            set_data(k % 2 == 1, 4'h0, 32'h4, 32'h0);
            @(negedge clk);
            n_cmp++;
            if ({inst_gnt, data_gnt} !== {k % 2 == 0, k % 2 == 1}) begin
                n_bad++;
                $display("FAIL b2b_gnt[%0d]: got %b%b", k, inst_gnt, data_gnt);
            end
            if (k > 0) begin
                n_cmp++;
                if ({inst_rvalid, data_rvalid, data_rdata} !== {k % 2 == 1, k % 2 == 0,
                    ((k % 2 == 1) ? 32'hC0DE_0000 : 32'hC0DE_0001)}) begin
                    n_bad++;
                    $display("FAIL b2b_resp[%0d]: got %b%b/%h", k, inst_rvalid, data_rvalid,
                             data_rdata);
                end
            end
            step();
        end
        set_inst(1'b0, 32'h0);
        set_data(1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        n_cmp++;
        if ({inst_rvalid, data_rvalid, data_rdata} !== {2'b01, 32'hC0DE_0001}) begin
            n_bad++;
            $display("FAIL b2b_tail: got %b%b/%h want 01/c0de0001",
                     inst_rvalid, data_rvalid, data_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid_access();
        set_data(1'b1, 4'h0, 32'hC, 32'h0);
        @(negedge clk);
        n_cmp++;
        if (data_gnt !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_gnt: got %b want 1", data_gnt);
        end
        step();
        resetn = 1'b0;
        set_data(1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        n_cmp++;
        if ({inst_gnt, data_gnt, inst_rvalid, data_rvalid, sram_en, sram_we, inst_rdata,
             data_rdata, sram_addr, sram_wdata} !== 137'd0) begin
            n_bad++;
            $display("FAIL mid_reset_outs: got %b%b%b%b%b/%h/%h", inst_gnt, data_gnt,
                     inst_rvalid, data_rvalid, sram_en, sram_we, data_rdata);
        end
        step();
        resetn = 1'b1;
        set_data(1'b1, 4'h0, 32'hC, 32'h0);
        @(negedge clk);
        n_cmp++;
        if ({data_gnt, data_rvalid, inst_rvalid} !== 3'b000) begin
            n_bad++;
            $display("FAIL mid_release: got %b%b%b want 000", data_gnt, data_rvalid, inst_rvalid);
        end
        step();
        @(negedge clk);
        n_cmp++;
        if ({data_gnt, data_rvalid} !== 2'b10) begin
            n_bad++;
            $display("FAIL mid_second_edge: got %b%b want 10", data_gnt, data_rvalid);
        end
        step();
        set_data(1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        n_cmp++;
        if ({data_rvalid, data_rdata} !== {1'b1, 32'hC0DE_0003}) begin
            n_bad++;
            $display("FAIL mid_reread: got %b/%h want 1/c0de0003", data_rvalid, data_rdata);
        end
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) written[i] = 1'b0;
        test_reset();
        test_fetch();
        test_write_priority();
        test_starvation();
        test_drop();
        test_back_to_back();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
